// File: rtl/decode_fetch_queue.sv
// -----------------------------------------------------------------------------
// decode_fetch_queue
//
// Fetch-to-decode stage buffer. Holds up to DEPTH fetched {pc, inst} pairs in a
// circular FIFO so fetch can keep running while decode stalls, until the queue
// fills. Both sides use valid/ready handshakes. flushD drops every entry on a
// branch redirect. While the queue is empty, decode sees a NOP bubble.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flushD     synchronous flush, discards all entries (and any push/pop) this cycle
//   in_valid   fetch presents pc_in/inst_in
//   in_ready   queue can accept an entry this cycle (registered state only)
//   pc_in      fetched PC
//   inst_in    fetched instruction
//   out_valid  head entry valid for decode
//   out_ready  decode consumes the head entry this cycle
//   pcD        head PC, 0 when empty
//   instD      head instruction, NOP_INST when empty
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module decode_fetch_queue #(
   parameter int                 PC_W     = 12,
   parameter int                 INST_W   = 16,
   parameter int                 DEPTH    = 4,
   parameter logic [INST_W-1:0]  NOP_INST = '0,
   localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flushD,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [INST_W-1:0] inst_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   pcD,
   output logic [INST_W-1:0] instD,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = PC_W + INST_W;

   logic [ENTRY_W-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [ENTRY_W-1:0] head_entry;
   logic               push;
   logic               pop;

   // in_ready looks only at occupancy, so a full queue refuses a push even
   // when decode is draining that same cycle.
   assign in_ready  = (count_reg != CNT_W'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_reg;

   // Pointers and occupancy. Pointers are log2(DEPTH) bits and wrap by
   // natural rollover since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flushD) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

   // Storage is not reset: the output mux masks it while the queue is empty.
   // A push in a flush cycle is dropped, so the write is gated by flushD too.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && !flushD && (wr_ptr_reg == PTR_W'(gi))) begin
               mem_reg[gi] <= {pc_in, inst_in};
            end
         end
      end
   endgenerate

   // Head is read combinationally from registered state; a new entry shows
   // up one cycle after its push at the earliest (no bypass).
   assign head_entry = mem_reg[rd_ptr_reg];

   always_comb begin
      pcD   = '0;
      instD = NOP_INST;
      if (out_valid) begin
         pcD   = head_entry[ENTRY_W-1:INST_W];
         instD = head_entry[INST_W-1:0];
      end
   end

endmodule

// File: tb/tb_decode_fetch_queue.sv
module tb_decode_fetch_queue;

   localparam int              PC_W   = 12;
   localparam int              INST_W = 16;
   localparam int              DEPTH  = 4;
   localparam logic [15:0]     NOP    = 16'hA5A5;
   localparam int              CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              reset;
   logic              flushD;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   pc_in;
   logic [INST_W-1:0] inst_in;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   pcD;
   logic [INST_W-1:0] instD;
   logic [CNT_W-1:0]  count;

   int vectors;
   int miscompares;

   decode_fetch_queue #(
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .DEPTH    (DEPTH),
      .NOP_INST (NOP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flushD    (flushD),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc_in     (pc_in),
      .inst_in   (inst_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pcD       (pcD),
      .instD     (instD),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      flushD      = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      pc_in       = '0;
      inst_in     = '0;

      // Reset state
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_pcD",       32'(pcD),       32'd0);
      check("rst_instD",     32'(instD),     32'(NOP));
      check("rst_count",     32'(count),     32'd0);
      #10 reset = 1'b1;      // released between edges
      tick();

      // 1. Single push, visible only after the edge
      in_valid = 1'b1; pc_in = 12'h010; inst_in = 16'h1234;
      #1;
      check("t1_no_bypass", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_pcD",       32'(pcD),       32'h010);
      check("t1_instD",     32'(instD),     32'h1234);
      check("t1_count",     32'(count),     32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_drain_count", 32'(count), 32'd0);

      // 2. Fill past full with decode stalled, then drain in order
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; pc_in = 12'h100 + 12'(i); inst_in = 16'h2000 + 16'(i);
         #1;
         check("t2_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      in_valid = 1'b0;
      check("t2_full_count",    32'(count),    32'd4);
      check("t2_full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; pc_in = 12'h1FF; inst_in = 16'hFFFF; out_ready = 1'b1;
      #1;
      check("t2_full_pop_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t2_pop_pcD",   32'(pcD),   32'h100 + 32'(i));
         check("t2_pop_instD", 32'(instD), 32'h2000 + 32'(i));
         tick();
      end
      out_ready = 1'b0;
      check("t2_empty_count", 32'(count),     32'd0);
      check("t2_empty_valid", 32'(out_valid), 32'd0);

      // 3. Steady stream, push and pop every cycle across pointer wrap
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; pc_in = 12'h300 + 12'(i); inst_in = 16'h3000 + 16'(i * 3);
         tick();
         check("t3_count", 32'(count), 32'd1);
         check("t3_pcD",   32'(pcD),   32'h300 + 32'(i));
         check("t3_instD", 32'(instD), 32'h3000 + 32'(i * 3));
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("t3_drain_count", 32'(count), 32'd0);

      // 4. Flush with 3 entries held and a push in the same cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; pc_in = 12'h400 + 12'(i); inst_in = 16'h4000 + 16'(i);
         tick();
      end
      check("t4_pre_count", 32'(count), 32'd3);
      flushD = 1'b1; in_valid = 1'b1; pc_in = 12'h777; inst_in = 16'h7777;
      tick();
      flushD = 1'b0; in_valid = 1'b0;
      check("t4_count",     32'(count),     32'd0);
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_in_ready",  32'(in_ready),  32'd1);
      check("t4_pcD",       32'(pcD),       32'd0);
      check("t4_instD",     32'(instD),     32'(NOP));
      in_valid = 1'b1; pc_in = 12'h455; inst_in = 16'h4455;
      tick();
      in_valid = 1'b0;
      check("t4_post_count", 32'(count), 32'd1);
      check("t4_post_pcD",   32'(pcD),   32'h455);
      check("t4_post_instD", 32'(instD), 32'h4455);

      // 5. Async reset between edges with 2 entries held
      in_valid = 1'b1; pc_in = 12'h500; inst_in = 16'h5000;
      tick();
      in_valid = 1'b0;
      check("t5_pre_count", 32'(count), 32'd2);
      #2 reset = 1'b0;
      #1;
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_in_ready",  32'(in_ready),  32'd1);
      check("t5_count",     32'(count),     32'd0);
      check("t5_instD",     32'(instD),     32'(NOP));
      #2 reset = 1'b1;
      tick();

      // 6. Pop requests on an empty queue are ignored
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_count",     32'(count),     32'd0);
         check("t6_out_valid", 32'(out_valid), 32'd0);
         check("t6_instD",     32'(instD),     32'(NOP));
      end
      out_ready = 1'b0;
      in_valid = 1'b1; pc_in = 12'h600; inst_in = 16'h6000;
      tick();
      in_valid = 1'b0;
      check("t6_push_count", 32'(count), 32'd1);
      check("t6_push_pcD",   32'(pcD),   32'h600);
      check("t6_push_instD", 32'(instD), 32'h6000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
